mem_responder: RTL

- Responder end of the CPU data/instruction memory port. Accepts word, half or byte requests from the multicycle control path, serves them from an internal byte-addressed big-endian store after a programmable number of wait states, and returns read data with a done pulse.
- Flags misaligned and out-of-range accesses so the control unit can raise an exception and load EPC.
- Replaces the fixed-latency memory wherever variable latency must be exercised.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_lane_align.sv | 44 ++++
 rtl/mem_responder.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory responder: request size encodings, FSM states
// and the alignment rule used when a request is accepted.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_e;

    // Reserved size is reported as misaligned so the control path raises one exception type.
    function automatic logic misaligned(size_e sz, logic [1:0] lo);
        case (sz)
            SZ_WORD: return (lo != 2'b00);
            SZ_HALF: return lo[0];
            SZ_BYTE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the multicycle control path (master)
// and the memory responder (slave).
interface mem_responder_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        err_align;
    logic        err_range;

    modport master (
        output req, wr, size, addr, wdata,
        input  ready, done, rdata, err_align, err_range
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output ready, done, rdata, err_align, err_range
    );

endinterface

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: maps a right-aligned request onto the four byte
// lanes of the containing word, and extracts/right-aligns read data from it.
module mem_lane_align
    import mem_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wlane_o,
    output logic [31:0] rdata_o
);

    // be_o[3] is the lowest-addressed byte, which sits in bits [31:24].
    always_comb begin
        be_o    = '0;
        wlane_o = '0;
        rdata_o = '0;
        case (size_i)
            SZ_WORD: begin
                be_o    = 4'b1111;
                wlane_o = wdata_i;
                rdata_o = rword_i;
            end
            SZ_HALF: begin
                be_o    = offset_i[1] ? 4'b0011 : 4'b1100;
                wlane_o = {2{wdata_i[15:0]}};
                rdata_o = {16'h0000, offset_i[1] ? rword_i[15:0] : rword_i[31:16]};
            end
            SZ_BYTE: begin
                wlane_o = {4{wdata_i[7:0]}};
                case (offset_i)
                    2'd0: begin be_o = 4'b1000; rdata_o = {24'h0, rword_i[31:24]}; end
                    2'd1: begin be_o = 4'b0100; rdata_o = {24'h0, rword_i[23:16]}; end
                    2'd2: begin be_o = 4'b0010; rdata_o = {24'h0, rword_i[15:8]};  end
                    default: begin be_o = 4'b0001; rdata_o = {24'h0, rword_i[7:0]}; end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Variable-latency memory responder: byte-addressed big-endian store served
// through a request/wait/access/response FSM with alignment and range flags.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter bit          INIT_ZERO   = 1'b1
)(
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0]  WC = 4'(WAIT_CYCLES);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wr_q, wr_d;
    size_e           size_q, size_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            ealign_q, ealign_d;
    logic            erange_q, erange_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            mem_we;

    logic [7:0]      mem_q [DEPTH];
    logic [AW-3:0]   word_idx;
    logic [31:0]     rword;
    logic [3:0]      be;
    logic [31:0]     wlane;
    logic [31:0]     lane_rdata;

    assign word_idx = addr_q[AW-1:2];
    assign rword    = {mem_q[{word_idx, 2'd0}], mem_q[{word_idx, 2'd1}],
                       mem_q[{word_idx, 2'd2}], mem_q[{word_idx, 2'd3}]};

    mem_lane_align u_lane (
        .size_i   (size_q),
        .offset_i (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .rword_i  (rword),
        .be_o     (be),
        .wlane_o  (wlane),
        .rdata_o  (lane_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ealign_d = ealign_q;
        erange_d = erange_q;
        rdata_d  = rdata_q;
        mem_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    wr_d     = bus.wr;
                    size_d   = size_e'(bus.size);
                    addr_d   = bus.addr[AW-1:0];
                    wdata_d  = bus.wdata;
                    ealign_d = misaligned(size_e'(bus.size), bus.addr[1:0]);
                    erange_d = (bus.addr >= 32'(DEPTH));
                    cnt_d    = '0;
                    state_d  = (WC == 4'd0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_d == WC) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (ealign_q || erange_q) rdata_d = '0;
                else if (wr_q)            mem_we  = 1'b1;
                else                      rdata_d = lane_rdata;
                state_d = S_RESP;
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            size_q   <= SZ_WORD;
            addr_q   <= '0;
            wdata_q  <= '0;
            ealign_q <= 1'b0;
            erange_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ealign_q <= ealign_d;
            erange_q <= erange_d;
            rdata_q  <= rdata_d;
        end
    end

    // Reset wins over a write in ACCESS, so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (INIT_ZERO) mem_q <= '{default: '0};
        end else if (mem_we) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (be[3-k]) mem_q[{word_idx, 2'(k)}] <= wlane[31-8*k -: 8];
            end
        end
    end

    assign bus.ready     = (state_q == S_IDLE);
    assign bus.done      = (state_q == S_RESP);
    assign bus.rdata     = rdata_q;
    assign bus.err_align = ealign_q;
    assign bus.err_range = erange_q;

endmodule
